// File: rtl/grid_renderer.sv
// Board-to-framebuffer renderer: redraws only rows that changed since the last
// redraw, emitting one pixel write per cycle with no gaps between dirty rows.
module grid_renderer #(
    parameter int ROWS       = 10,
    parameter int COLS       = 40,
    parameter int CELL_PX    = 8,
    parameter int X_OFF      = 0,
    parameter int Y_OFF      = 0,
    parameter int GRID_LINES = 1
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [ROWS*COLS-1:0] board,
    input  logic [1:0]           mode,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [10:0]          x,
    output logic [9:0]           y,
    output logic                 pixel_color,
    output logic                 pixel_write
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int NW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CW = $clog2(CELL_PX);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PLAN = 2'd1;
    localparam logic [1:0] SCAN = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]                      state_q, state_d;
    logic [ROWS-1:0][COLS-1:0]       snap_q, shown_q;
    logic [1:0]                      mode_q, shown_mode_q;
    logic                            force_full_q;
    logic [ROWS-1:0]                 dirty_q, dirty_d, plan_dirty, remaining;
    logic [RW-1:0]                   row_q, row_d, next_row;
    logic [NW-1:0]                   col_q, col_d;
    logic [CW-1:0]                   px_q, px_d, py_q, py_d;
    logic                            full, last_px, last_col, last_py, row_end, scan, grid;

    assign last_px  = (px_q == CW'(CELL_PX - 1));
    assign last_col = (col_q == NW'(COLS - 1));
    assign last_py  = (py_q == CW'(CELL_PX - 1));
    assign row_end  = last_px && last_col && last_py;

    always_comb begin
        full = force_full_q || (mode_q != shown_mode_q) || mode_q[1];
        for (int r = 0; r < ROWS; r++)
            plan_dirty[r] = full || (snap_q[r] != shown_q[r]);
    end

    // Rows still owed after this cycle: all planned rows in PLAN, minus the
    // row just finishing in SCAN. The lowest of them is scanned next.
    always_comb begin
        remaining = (state_q == PLAN) ? plan_dirty : dirty_q;
        if (state_q == SCAN) begin
            for (int r = 0; r < ROWS; r++)
                if (RW'(r) == row_q) remaining[r] = 1'b0;
        end
        next_row = '0;
        for (int r = ROWS - 1; r >= 0; r--)
            if (remaining[r]) next_row = RW'(r);
    end

    always_comb begin
        state_d = state_q;
        dirty_d = dirty_q;
        row_d   = row_q;
        col_d   = col_q;
        px_d    = px_q;
        py_d    = py_q;
        case (state_q)
            IDLE: if (start) state_d = PLAN;
            PLAN: begin
                dirty_d = plan_dirty;
                col_d   = '0;
                px_d    = '0;
                py_d    = '0;
                row_d   = next_row;
                state_d = (|remaining) ? SCAN : DONE;
            end
            SCAN: begin
                px_d = last_px ? '0 : px_q + CW'(1);
                if (last_px) col_d = last_col ? '0 : col_q + NW'(1);
                if (last_px && last_col) py_d = last_py ? '0 : py_q + CW'(1);
                if (row_end) begin
                    dirty_d = remaining;
                    row_d   = next_row;
                    if (!(|remaining)) state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q      <= IDLE;
            snap_q       <= '0;
            shown_q      <= '0;
            mode_q       <= 2'b00;
            shown_mode_q <= 2'b00;
            force_full_q <= 1'b1;
            dirty_q      <= '0;
            row_q        <= '0;
            col_q        <= '0;
            px_q         <= '0;
            py_q         <= '0;
        end else begin
            state_q <= state_d;
            dirty_q <= dirty_d;
            row_q   <= row_d;
            col_q   <= col_d;
            px_q    <= px_d;
            py_q    <= py_d;
            if (state_q == IDLE && start) begin
                snap_q <= board;
                mode_q <= mode;
            end
            if (state_q == SCAN && row_end) shown_q[row_q] <= snap_q[row_q];
            // Clear mode leaves stale content behind, so the next redraw repaints all.
            if (state_q == DONE) begin
                shown_mode_q <= mode_q;
                force_full_q <= mode_q[1];
            end
        end
    end

    assign scan        = (state_q == SCAN);
    assign grid        = (GRID_LINES != 0) && (px_q == '0 || py_q == '0);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign pixel_write = scan;
    assign pixel_color = scan && !mode_q[1] && !grid && (snap_q[row_q][col_q] ^ (mode_q == 2'b01));
    assign x = scan ? 11'(X_OFF) + 11'(col_q) * 11'(CELL_PX) + 11'(px_q) : 11'd0;
    assign y = scan ? 10'(Y_OFF) + 10'(row_q) * 10'(CELL_PX) + 10'(py_q) : 10'd0;
endmodule

// File: tb/tb_grid_renderer.sv
// Self-checking bench for grid_renderer on a 2x3 board of 2-pixel cells.
module tb_grid_renderer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] board = '0;
    logic [1:0] mode = '0;
    logic       start = 1'b0, start_g = 1'b0;
    logic       busy, done, pc, pw, gbusy, gdone, gpc, gpw;
    logic [10:0] x, gx;
    logic [9:0]  y, gy;

    int checks = 0, errors = 0;
    int wx[$], wy[$], wc[$], wn[$];
    int ex[$], ey[$], ec[$];
    int done_n, done_cnt, busy1;

    // Reference state: what the screen currently shows.
    logic [2:0] m_shown[2];
    logic [1:0] m_shown_mode;
    bit         m_force;

    grid_renderer #(.ROWS(2), .COLS(3), .CELL_PX(2), .X_OFF(0), .Y_OFF(0), .GRID_LINES(0)) u_dut (
        .Clock(clk), .Reset(rst_n), .board(board), .mode(mode), .start(start),
        .busy(busy), .done(done), .x(x), .y(y), .pixel_color(pc), .pixel_write(pw));

    grid_renderer #(.ROWS(2), .COLS(3), .CELL_PX(2), .X_OFF(0), .Y_OFF(0), .GRID_LINES(1)) u_grid (
        .Clock(clk), .Reset(rst_n), .board(board), .mode(mode), .start(start_g),
        .busy(gbusy), .done(gdone), .x(gx), .y(gy), .pixel_color(gpc), .pixel_write(gpw));

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_shown[0] = '0; m_shown[1] = '0; m_shown_mode = 2'b00; m_force = 1'b1;
    endfunction

    function automatic void model_redraw(input logic [5:0] b, input logic [1:0] m, input bit gl);
        bit full, clr;
        logic [2:0] row;
        ex.delete(); ey.delete(); ec.delete();
        clr  = m[1];
        full = m_force || (m != m_shown_mode) || clr;
        for (int r = 0; r < 2; r++) begin
            row = b[r*3 +: 3];
            if (full || row != m_shown[r]) begin
                for (int py = 0; py < 2; py++)
                    for (int c = 0; c < 3; c++)
                        for (int px = 0; px < 2; px++) begin
                            ex.push_back(c*2 + px);
                            ey.push_back(r*2 + py);
                            if (clr || (gl && (px == 0 || py == 0))) ec.push_back(0);
                            else ec.push_back(int'(row[c] ^ (m == 2'b01)));
                        end
                m_shown[r] = row;
            end
        end
        m_shown_mode = m;
        m_force = clr;
    endfunction

    function automatic int pix(input int xx, input int yy);
        for (int i = 0; i < wx.size(); i++)
            if (wx[i] == xx && wy[i] == yy) return wc[i];
        return -1;
    endfunction

    // Fire one redraw and record every write with its cycle offset from the start edge.
    task automatic capture(input logic [5:0] b, input logic [1:0] m, input bit g);
        wx.delete(); wy.delete(); wc.delete(); wn.delete();
        done_n = -1; done_cnt = 0; busy1 = -1;
        @(negedge clk);
        board = b; mode = m;
        if (g) start_g = 1'b1; else start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; start_g = 1'b0;
        board = 6'($urandom); mode = 2'($urandom);
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (n == 1) busy1 = g ? int'(gbusy) : int'(busy);
            if (g ? gpw : pw) begin
                wx.push_back(int'(g ? gx : x)); wy.push_back(int'(g ? gy : y));
                wc.push_back(int'(g ? gpc : pc)); wn.push_back(n);
            end
            if (g ? gdone : done) begin
                done_cnt++; done_n = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, done, pw, pc} !== 4'b0 || x !== 11'd0 || y !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b pw=%b pc=%b x=%0d y=%0d, required all 0",
                     busy, done, pw, pc, x, y);
        end
    endtask

    task automatic test_basic();
        int bad;
        model_redraw(6'b000101, 2'b00, 0);
        capture(6'b000101, 2'b00, 0);
        checks++;
        if (wx.size() != 24) begin errors++; $display("FAIL basic_count: got %0d writes, required 24", wx.size()); end
        checks++;
        if (busy1 != 1) begin errors++; $display("FAIL basic_busy: busy in PLAN cycle=%0d, required 1", busy1); end
        bad = 0;
        for (int i = 0; i < wn.size(); i++) if (wn[i] != i + 2) bad++;
        checks++;
        if (bad != 0 || wn.size() == 0) begin errors++; $display("FAIL basic_contig: %0d gaps/offsets wrong, required writes from cycle 2 back to back", bad); end
        checks++;
        if (done_n != 26 || done_cnt != 1) begin errors++; $display("FAIL basic_done: done at cycle %0d, required 26", done_n); end
        checks++;
        if (pix(0,0) != 1 || pix(1,0) != 1 || pix(2,0) != 0 || pix(3,0) != 0 || pix(4,0) != 1) begin
            errors++;
            $display("FAIL basic_pixels: row0 = %0d %0d %0d %0d %0d, required 1 1 0 0 1",
                     pix(0,0), pix(1,0), pix(2,0), pix(3,0), pix(4,0));
        end
    endtask

    task automatic test_no_change();
        model_redraw(6'b000101, 2'b00, 0);
        capture(6'b000101, 2'b00, 0);
        checks++;
        if (wx.size() != 0 || done_n != 2) begin
            errors++;
            $display("FAIL no_change: %0d writes, done at cycle %0d, required 0 writes and done at 2", wx.size(), done_n);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL idle_after_done: busy=%b done=%b, required 0 0", busy, done); end
    endtask

    task automatic test_row_change();
        int bad = 0;
        model_redraw(6'b010101, 2'b00, 0);
        capture(6'b010101, 2'b00, 0);
        for (int i = 0; i < wy.size(); i++) if (wy[i] != 2 && wy[i] != 3) bad++;
        checks++;
        if (wx.size() != 12 || bad != 0) begin
            errors++;
            $display("FAIL row_change: %0d writes, %0d outside rows 2-3, required 12 and 0", wx.size(), bad);
        end
        checks++;
        if (pix(2,2) != 1) begin errors++; $display("FAIL row_change_pix: (2,2)=%0d, required 1", pix(2,2)); end
    endtask

    task automatic test_modes();
        logic [1:0] ms[3] = '{2'b01, 2'b10, 2'b00};
        for (int k = 0; k < 3; k++) begin
            int bad = 0;
            model_redraw(6'b010101, ms[k], 0);
            capture(6'b010101, ms[k], 0);
            for (int i = 0; i < wc.size() && i < ec.size(); i++)
                if (wc[i] != ec[i] || wx[i] != ex[i] || wy[i] != ey[i]) bad++;
            checks++;
            if (wx.size() != 24 || bad != 0 || wn.size() == 0 || wn[0] != 2) begin
                errors++;
                $display("FAIL mode_%0d: %0d writes, %0d wrong pixels, required 24 and 0", ms[k], wx.size(), bad);
            end
        end
    endtask

    task automatic test_grid();
        capture(6'b111111, 2'b00, 1);
        checks++;
        if (wx.size() != 24) begin errors++; $display("FAIL grid_count: %0d writes, required 24", wx.size()); end
        checks++;
        if (pix(0,0) != 0 || pix(1,0) != 0 || pix(1,1) != 1 || pix(3,3) != 1) begin
            errors++;
            $display("FAIL grid_pixels: (0,0)=%0d (1,0)=%0d (1,1)=%0d (3,3)=%0d, required 0 0 1 1",
                     pix(0,0), pix(1,0), pix(1,1), pix(3,3));
        end
    endtask

    task automatic test_reset_mid();
        int nw = 0;
        bit hit = 0;
        @(negedge clk);
        board = 6'b101010; mode = 2'b00; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 60 && !hit; n++) begin
            @(negedge clk);
            if (pw) nw++;
            if (nw == 2) start = 1'b1;
            if (nw == 5) begin
                rst_n = 1'b0;
                #1;
                hit = 1;
                checks++;
                if ({busy, done, pw, pc} !== 4'b0 || x !== 11'd0 || y !== 10'd0) begin
                    errors++;
                    $display("FAIL reset_mid: busy=%b done=%b pw=%b pc=%b x=%0d y=%0d, required all 0",
                             busy, done, pw, pc, x, y);
                end
            end
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL reset_mid_timeout: saw %0d writes, required 5", nw); end
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        model_redraw(6'b101010, 2'b00, 0);
        capture(6'b101010, 2'b00, 0);
        checks++;
        if (wx.size() != 24 || done_n != 26) begin
            errors++;
            $display("FAIL reset_full_redraw: %0d writes, done at %0d, required 24 and 26", wx.size(), done_n);
        end
    endtask

    task automatic test_random();
        logic [5:0] b = 6'b101010;
        logic [1:0] m;
        for (int it = 0; it < 30; it++) begin
            int bad = 0;
            if ($urandom_range(0, 2) != 0) b = b ^ (6'b1 << $urandom_range(0, 5));
            m = ($urandom_range(0, 9) < 6) ? 2'b00 : 2'($urandom);
            model_redraw(b, m, 0);
            capture(b, m, 0);
            for (int i = 0; i < wx.size() && i < ex.size(); i++)
                if (wx[i] != ex[i] || wy[i] != ey[i] || wc[i] != ec[i] || wn[i] != i + 2) bad++;
            checks++;
            if (wx.size() != ex.size() || bad != 0) begin
                errors++;
                $display("FAIL random_%0d: board=%b mode=%b got %0d writes (%0d wrong), required %0d",
                         it, b, m, wx.size(), bad, ex.size());
            end
            checks++;
            if (done_n != 2 + ex.size() || done_cnt != 1) begin
                errors++;
                $display("FAIL random_done_%0d: done at cycle %0d, required %0d", it, done_n, 2 + ex.size());
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_basic();
        test_no_change();
        test_row_change();
        test_modes();
        test_grid();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
